// File: rtl/ifetch_pkg.sv
// Shared types for the instruction fetch controller: FSM encoding, NOP word and
// the {pc, instr} entry carried through the fetch buffer.
package ifetch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      FAULT = 2'd2
   } state_t;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous show-ahead fetch buffer with flush; push while full is accepted
// only when the head is popped in the same cycle.
module ifetch_fifo
   import ifetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   push,
   input  logic   pop,
   input  logic   flush,
   input  entry_t din,
   output entry_t head,
   output logic   full,
   output logic   empty
);

   localparam int AW = $clog2(DEPTH);

   entry_t         mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [AW:0]    count;
   logic           do_push;
   logic           do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage carries data only; validity is tracked by the pointers above.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: PC/FSM, range and alignment fault detection, fetch buffer.
// Define IFETCH_PERF_EN to add the perf_fetched / perf_stall counters.
module instr_fetch_ctrl
   import ifetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] START_ADDR = 32'h0000_0000,
   parameter int          MEM_DEPTH  = 256,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_en,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   output logic        fetch_fault,
`ifdef IFETCH_PERF_EN
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_stall,
`endif
   output logic        busy
);

   localparam logic [31:0] DEPTH_WORDS = MEM_DEPTH;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] offset;
   logic        pc_legal;
   logic        do_push;
   logic        do_pop;
   logic        fifo_full;
   logic        fifo_empty;
   entry_t      push_entry;
   entry_t      head;

   // Offset is taken modulo 2^32 so a PC below START_ADDR lands far out of range.
   assign offset     = pc_q - START_ADDR;
   assign pc_legal   = (pc_q[1:0] == 2'b00) && ({2'b00, offset[31:2]} < DEPTH_WORDS);
   assign do_pop     = !fifo_empty && if_ready && !redirect_valid;
   assign push_entry = {pc_q, imem_instr};

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      do_push = 1'b0;
      if (redirect_valid) begin
         state_d = fetch_en ? FETCH : IDLE;
         pc_d    = redirect_pc;
      end else begin
         case (state_q)
            IDLE:  if (fetch_en) state_d = FETCH;
            FETCH: begin
               if (!fetch_en) begin
                  state_d = IDLE;
               end else if (!pc_legal) begin
                  state_d = FAULT;
               end else if (!fifo_full || do_pop) begin
                  do_push = 1'b1;
                  pc_d    = pc_q + 32'd4;
               end
            end
            FAULT:   state_d = FAULT;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   ifetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (do_push),
      .pop   (do_pop),
      .flush (redirect_valid),
      .din   (push_entry),
      .head  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Head fields are forced to zero while the buffer is empty.
   assign imem_addr   = pc_q;
   assign if_valid    = !fifo_empty;
   assign if_pc       = if_valid ? head.pc : 32'd0;
   assign if_instr    = if_valid ? head.instr : 32'd0;
   assign fetch_fault = (state_q == FAULT);
   assign busy        = (state_q != IDLE) || !fifo_empty;

`ifdef IFETCH_PERF_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_fetched <= 32'd0;
         perf_stall   <= 32'd0;
      end else begin
         if (do_push) perf_fetched <= perf_fetched + 32'd1;
         if ((state_q == FETCH) && fifo_full && !do_pop) perf_stall <= perf_stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed scenarios plus a randomized phase, scored
// against a queue of expected {pc, instr} entries maintained cycle by cycle.
module tb_instr_fetch_ctrl;

   localparam logic [31:0] START  = 32'h0000_0000;
   localparam int          DEPTH  = 32;
   localparam int          FDEPTH = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetch_en;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        fetch_fault;
   logic        busy;
`ifdef IFETCH_PERF_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_stall;
`endif

   always #5 clk = ~clk;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return {~a[15:0], a[15:0]};
   endfunction

   assign imem_instr = instr_of(imem_addr);

   instr_fetch_ctrl #(
      .RESET_PC   (32'h0000_0000),
      .START_ADDR (START),
      .MEM_DEPTH  (DEPTH),
      .FIFO_DEPTH (FDEPTH)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .fetch_en       (fetch_en),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_addr      (imem_addr),
      .imem_instr     (imem_instr),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_pc          (if_pc),
      .if_instr       (if_instr),
      .fetch_fault    (fetch_fault),
`ifdef IFETCH_PERF_EN
      .perf_fetched   (perf_fetched),
      .perf_stall     (perf_stall),
`endif
      .busy           (busy)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   // Reference: expected buffer contents, PC and state (0 idle, 1 fetch, 2 fault).
   logic [63:0] exp_q[$];
   logic [31:0] m_pc;
   int          m_state;
   bit          m_ok = 1'b0;
   logic [31:0] m_off;
   bit          m_legal;
   bit          m_full;
   bit          m_pop;

   initial begin
      forever begin
         @(negedge clk);
         if (m_ok) begin
            check("sb_imem_addr", imem_addr, m_pc);
            check("sb_if_valid", if_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
               check("sb_if_pc", if_pc, exp_q[0][63:32]);
               check("sb_if_instr", if_instr, exp_q[0][31:0]);
            end
            check("sb_fetch_fault", fetch_fault, m_state == 2);
            check("sb_busy", busy, (m_state != 0) || (exp_q.size() != 0));
         end
         if (!rst_n) begin
            exp_q.delete();
            m_pc    = 32'd0;
            m_state = 0;
            m_ok    = 1'b1;
         end else begin
            m_off   = m_pc - START;
            m_legal = (m_pc[1:0] == 2'b00) && ((m_off >> 2) < 32'(DEPTH));
            m_full  = (exp_q.size() == FDEPTH);
            m_pop   = (exp_q.size() != 0) && if_ready;
            if (redirect_valid) begin
               exp_q.delete();
               m_pc    = redirect_pc;
               m_state = fetch_en ? 1 : 0;
            end else begin
               if (m_pop) void'(exp_q.pop_front());
               case (m_state)
                  0: if (fetch_en) m_state = 1;
                  1: begin
                     if (!fetch_en) m_state = 0;
                     else if (!m_legal) m_state = 2;
                     else if (!m_full || m_pop) begin
                        exp_q.push_back({m_pc, instr_of(m_pc)});
                        m_pc = m_pc + 32'd4;
                     end
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic redirect_to(input logic [31:0] pc);
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      step(1);
      redirect_valid = 1'b0;
   endtask

   logic [31:0] rpc;

   initial begin
      rst_n = 1'b0; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0; if_ready = 1'b0;
      step(3);
      check("rst_if_valid", if_valid, 1'b0);
      check("rst_if_pc", if_pc, 32'd0);
      check("rst_if_instr", if_instr, 32'd0);
      check("rst_fault", fetch_fault, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_imem_addr", imem_addr, 32'd0);

      // Streaming fetch with decode always ready
      rst_n = 1'b1; fetch_en = 1'b1; if_ready = 1'b1;
      step(1);
      check("t1_no_entry_yet", if_valid, 1'b0);
      step(1);
      check("t1_valid", if_valid, 1'b1);
      check("t1_pc0", if_pc, 32'h0);
      step(1);
      check("t1_pc4", if_pc, 32'h4);
      step(1);
      check("t1_pc8", if_pc, 32'h8);
      check("t1_instr8", if_instr, instr_of(32'h8));

      // Decode back-pressure fills the buffer and freezes the PC
      rst_n = 1'b0; step(1);
      rst_n = 1'b1; if_ready = 1'b0;
      step(6);
      check("t2_head_held", if_pc, 32'h0);
      check("t2_pc_frozen", imem_addr, 32'h8);
      if_ready = 1'b1;
      step(1);
      check("t2_rel_pc4", if_pc, 32'h4);
      step(1);
      check("t2_rel_pc8", if_pc, 32'h8);
      step(1);
      check("t2_rel_pcC", if_pc, 32'hC);

      // Redirect flushes buffered 0x8/0xC and ignores the same-cycle pop
      rst_n = 1'b0; if_ready = 1'b0; step(1);
      rst_n = 1'b1;
      step(3);
      if_ready = 1'b1;
      step(2);
      check("t3_head8", if_pc, 32'h8);
      redirect_to(32'h40);
      check("t3_flushed", if_valid, 1'b0);
      check("t3_newpc", imem_addr, 32'h40);
      step(1);
      check("t3_first", if_pc, 32'h40);

      // Misaligned redirect faults; a legal redirect recovers
      redirect_to(32'h42);
      check("t4_not_yet", fetch_fault, 1'b0);
      step(1);
      check("t4_fault", fetch_fault, 1'b1);
      step(3);
      check("t4_pc_frozen", imem_addr, 32'h42);
      check("t4_no_push", if_valid, 1'b0);
      redirect_to(32'h10);
      check("t4_cleared", fetch_fault, 1'b0);
      step(1);
      check("t4_resume", if_pc, 32'h10);

      // Run off the end of memory
      redirect_to(32'h70);
      step(5);
      check("t5_fault", fetch_fault, 1'b1);
      check("t5_pc", imem_addr, 32'h80);
      check("t5_drained", if_valid, 1'b0);
      check("t5_busy_fault", busy, 1'b1);

      // Halt and resume, then reset mid-stream
      fetch_en = 1'b0;
      redirect_to(32'h0);
      check("t6_idle", busy, 1'b0);
      fetch_en = 1'b1;
      step(4);
      fetch_en = 1'b0;
      step(4);
      check("t6_held_pc", imem_addr, 32'hC);
      check("t6_halt_empty", if_valid, 1'b0);
      fetch_en = 1'b1;
      step(2);
      check("t6_resume", if_pc, 32'hC);
      step(2);
      rst_n = 1'b0;
      step(1);
      check("t6_rst_valid", if_valid, 1'b0);
      check("t6_rst_pc", imem_addr, 32'h0);
      check("t6_rst_busy", busy, 1'b0);
      rst_n = 1'b1;

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 5))
            0, 1, 2: rpc = 32'($urandom_range(0, 31)) << 2;
            3:       rpc = 32'h80;
            4:       rpc = (32'($urandom_range(0, 31)) << 2) + 32'd2;
            default: rpc = 32'hFFFF_FFFC;
         endcase
         if_ready       = ($urandom_range(0, 3) != 0);
         fetch_en       = ($urandom_range(0, 7) != 0);
         redirect_valid = ($urandom_range(0, 11) == 0);
         redirect_pc    = rpc;
         rst_n          = ($urandom_range(0, 99) != 0);
         step(1);
      end
      rst_n = 1'b1; redirect_valid = 1'b0;
      step(2);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
